// File: rtl/joust2_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : joust2_rom_loader
//  Description : Accepts an HPS ROM download, forwards in-range bytes to the
//                core ROMs one cycle later, keeps a running 16-bit checksum
//                and releases the core only after a complete, clean image.
//  Revision    : 1.0 - initial release
// ============================================================================
module joust2_rom_loader #(
    parameter int          ROM_SIZE  = 245760,
    parameter logic [15:0] ROM_INDEX = 16'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] ioctl_index,
    output logic [17:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] checksum
);

    localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
    localparam logic [18:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        download_q;
    logic [18:0] byte_count;
    logic        overflow;

    logic        index_match;
    logic        start;
    logic        in_load;
    logic        accept;
    logic        reject;
    logic        finish;
    logic [18:0] count_next;
    logic        overflow_next;
    logic        image_ok;

    assign index_match   = (ioctl_index == ROM_INDEX);
    assign start         = ioctl_download & ~download_q & index_match;
    assign in_load       = (state == ST_LOAD);
    assign accept        = in_load & ioctl_wr & index_match & (ioctl_addr <  ROM_LIMIT);
    assign reject        = in_load & ioctl_wr & index_match & (ioctl_addr >= ROM_LIMIT);
    assign finish        = in_load & ~ioctl_download;

    // A byte strobed on the falling-download cycle is folded in before the
    // completeness check, so the check uses the post-update count and flag.
    assign count_next    = (accept && (byte_count != CNT_MAX)) ? byte_count + 19'd1 : byte_count;
    assign overflow_next = overflow | reject;
    assign image_ok      = ({6'd0, count_next} == ROM_LIMIT) && !overflow_next;

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and state-decoded status outputs.
    always_comb begin
        state_next = state;
        core_hold  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;

        if (start) begin
            state_next = ST_LOAD;
        end else if (finish) begin
            state_next = image_ok ? ST_DONE : ST_ERROR;
        end

        core_hold  = (state != ST_DONE);
        load_done  = (state == ST_DONE);
        load_error = (state == ST_ERROR);
    end

    // Download edge tracking, byte forwarding, counting and checksum.
    // download_q resets to 1 so a download still held high across a reset
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            download_q <= 1'b1;
            byte_count <= '0;
            overflow   <= 1'b0;
            checksum   <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
        end else begin
            download_q <= ioctl_download;
            dn_wr      <= accept;
            if (accept) begin
                dn_addr <= ioctl_addr[17:0];
                dn_data <= ioctl_dout;
            end
            if (start) begin
                byte_count <= '0;
                overflow   <= 1'b0;
                checksum   <= '0;
            end else if (in_load) begin
                byte_count <= count_next;
                overflow   <= overflow_next;
                if (accept) begin
                    checksum <= checksum + {8'd0, ioctl_dout};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joust2_rom_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_joust2_rom_loader
//  Description : Randomized self-checking bench for joust2_rom_loader with a
//                transaction-level reference model (expected write queue,
//                byte count, overflow flag and checksum).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joust2_rom_loader;

    localparam int ROM_SIZE = 1024;
    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_DONE   = 2;
    localparam int M_ERROR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] ioctl_index = '0;
    logic [17:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] checksum;

    joust2_rom_loader #(
        .ROM_SIZE  (ROM_SIZE),
        .ROM_INDEX (16'd0)
    ) dut (
        .clk_sys        (clk),
        .reset          (rst),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_hold      (core_hold),
        .load_done      (load_done),
        .load_error     (load_error),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] a;
        logic [7:0]  d;
        int          c;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          p0;
    logic [17:0] last_a = '0;
    logic [7:0]  last_d = '0;

    // reference model of the loader
    int          m_state = M_IDLE;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_sum = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // compare the write port against the expected write queue
    task automatic mon();
        logic ew;
        while (q.size() > 0 && q[0].c < cyc) void'(q.pop_front());
        ew = (q.size() > 0) && (q[0].c == cyc);
        check("dn_wr", 32'(dn_wr), 32'(ew));
        if (dn_wr) pulses++;
        if (ew) begin
            last_a = q[0].a;
            last_d = q[0].d;
            void'(q.pop_front());
        end
        check("dn_addr", 32'(dn_addr), 32'(last_a));
        check("dn_data", 32'(dn_data), 32'(last_d));
    endtask

    // one clock: sample outputs on the falling edge, then step past the rising edge
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        last_a  = '0;
        last_d  = '0;
        m_state = M_IDLE;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_sum   = '0;
    endtask

    task automatic model_finish();
        if (m_state == M_LOAD)
            m_state = (m_cnt == ROM_SIZE && !m_ovf) ? M_DONE : M_ERROR;
    endtask

    task automatic check_status(input string tag);
        check({tag, ":load_done"},  32'(load_done),  32'(m_state == M_DONE));
        check({tag, ":load_error"}, 32'(load_error), 32'(m_state == M_ERROR));
        check({tag, ":core_hold"},  32'(core_hold),  32'(m_state != M_DONE));
        check({tag, ":checksum"},   32'(checksum),   32'(m_sum));
    endtask

    task automatic start_xfer(input logic [15:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (idx == 16'd0) begin
            m_state = M_LOAD;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_sum   = '0;
        end
        tick();
    endtask

    task automatic end_xfer();
        ioctl_download = 1'b0;
        model_finish();
        tick();
        tick();
    endtask

    task automatic send_byte(input int addr, input logic [7:0] data, input bit fall);
        exp_t e;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        if (fall) ioctl_download = 1'b0;
        if (m_state == M_LOAD && ioctl_index == 16'd0) begin
            if (addr < ROM_SIZE) begin
                e.a = 18'(addr);
                e.d = data;
                e.c = cyc + 1;
                q.push_back(e);
                m_cnt++;
                m_sum = m_sum + {8'd0, data};
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (fall) model_finish();
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic send_image(input int n, input bit ones, input bit b2b, input bit last_fall);
        for (int i = 0; i < n; i++) begin
            if (!b2b) repeat ($urandom_range(0, 2)) tick();
            send_byte(i, ones ? 8'h01 : 8'($urandom_range(0, 255)), last_fall && (i == n - 1));
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check_status("reset");
        rst = 1'b0;
        tick();

        // full image of 8'h01 with random gaps
        p0 = pulses;
        start_xfer(16'd0);
        send_image(ROM_SIZE, 1'b1, 1'b0, 1'b0);
        end_xfer();
        check_status("full_ones");
        check("full_ones:sum_const", 32'(checksum), 32'(16'(ROM_SIZE)));
        check("full_ones:pulses", 32'(pulses - p0), 32'(ROM_SIZE));

        // short image
        p0 = pulses;
        start_xfer(16'd0);
        send_image(100, 1'b0, 1'b0, 1'b0);
        end_xfer();
        check_status("short");
        check("short:pulses", 32'(pulses - p0), 32'd100);

        // full image plus one write past the end
        p0 = pulses;
        start_xfer(16'd0);
        send_image(ROM_SIZE, 1'b0, 1'b0, 1'b0);
        send_byte(ROM_SIZE, 8'($urandom_range(1, 255)), 1'b0);
        end_xfer();
        check_status("overflow");
        check("overflow:pulses", 32'(pulses - p0), 32'(ROM_SIZE));

        // clean random full image
        start_xfer(16'd0);
        send_image(ROM_SIZE, 1'b0, 1'b0, 1'b0);
        end_xfer();
        check_status("full_rand");

        // foreign-index transfer while DONE
        p0 = pulses;
        start_xfer(16'd1);
        send_image(200, 1'b0, 1'b0, 1'b0);
        end_xfer();
        check_status("index1");
        check("index1:pulses", 32'(pulses - p0), 32'd0);

        // reset in the middle of a load, download held high across it
        start_xfer(16'd0);
        send_image(50, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        check_status("in_reset");
        rst = 1'b0;
        tick();
        p0 = pulses;
        send_image(5, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("after_reset");
        check("after_reset:pulses", 32'(pulses - p0), 32'd0);
        end_xfer();
        check_status("after_reset_fall");
        start_xfer(16'd0);
        send_image(ROM_SIZE, 1'b0, 1'b0, 1'b0);
        end_xfer();
        check_status("reload");

        // back-to-back strobes, last one on the falling download
        p0 = pulses;
        start_xfer(16'd0);
        send_image(ROM_SIZE, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check_status("b2b_full");
        check("b2b_full:pulses", 32'(pulses - p0), 32'(ROM_SIZE));

        // one byte short, last strobe on the falling download
        start_xfer(16'd0);
        send_image(ROM_SIZE - 1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check_status("b2b_short");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/joust2_rom_loader.md
JOUST2_ROM_LOADER -- requirements
Module: joust2_rom_loader

Interface
REQ-001 Parameter ROM_SIZE, default 245760, SHALL be the exact number of bytes expected in a complete ROM image.
REQ-002 Parameter ROM_INDEX, default 16'd0, SHALL be the ioctl_index value that selects this loader.
REQ-003 clk_sys  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 ioctl_download  input  1  high while the HPS transfer is active.
REQ-006 ioctl_wr  input  1  one-cycle strobe for a valid byte.
REQ-007 ioctl_addr  input  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  input  8  download byte.
REQ-009 ioctl_index  input  16  download target selector.
REQ-010 dn_addr  output  18  registered write address to the core ROMs.
REQ-011 dn_data  output  8  registered write data.
REQ-012 dn_wr  output  1  one-cycle write strobe to the core ROMs.
REQ-013 core_hold  output  1  keeps the core in reset until a valid image is loaded.
REQ-014 load_done  output  1  level; a complete image was accepted.
REQ-015 load_error  output  1  level; the last transfer was short or overflowed.
REQ-016 checksum  output  16  running sum of accepted bytes, modulo 65536.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE and ERROR, encoded in one state register.
REQ-018 A transfer is "selected" when ioctl_download=1 and ioctl_index=ROM_INDEX.
REQ-019 Any state SHALL go to LOAD on the cycle a selected transfer is first seen (rising ioctl_download).
- On entry: byte counter=0, checksum=0, overflow flag=0, load_done=0, load_error=0.
REQ-020 In LOAD, a byte with ioctl_wr=1 and ioctl_addr<ROM_SIZE SHALL be accepted:
- dn_addr=ioctl_addr[17:0], dn_data=ioctl_dout, dn_wr=1 on the next cycle (latency 1).
- Byte counter +1.
- checksum += ioctl_dout, 16-bit wrap.
REQ-021 In LOAD, a write with ioctl_addr>=ROM_SIZE SHALL NOT assert dn_wr; it sets the overflow flag and leaves the counter and checksum unchanged.
REQ-022 dn_wr SHALL be high for exactly one cycle per accepted byte; back-to-back ioctl_wr on consecutive cycles SHALL produce back-to-back dn_wr.
REQ-023 When ioctl_download falls in LOAD, on the next cycle the state SHALL go to DONE if counter==ROM_SIZE and overflow=0, otherwise to ERROR.
REQ-024 A byte strobed on the same cycle ioctl_download falls SHALL still be accepted and counted before the check.
REQ-025 Unselected transfers (index mismatch) SHALL NOT affect state, counter, checksum or dn_wr.
REQ-026 core_hold SHALL be 1 in IDLE, LOAD and ERROR, and 0 only in DONE.
REQ-027 load_done SHALL be 1 only in DONE; load_error SHALL be 1 only in ERROR.
REQ-028 The byte counter SHALL be 19 bits wide and saturate at its maximum.
REQ-029 dn_addr and dn_data SHALL hold their last values when dn_wr=0.

Reset
REQ-030 While reset is asserted, outputs SHALL be:
- state=IDLE, dn_addr=0, dn_data=0, dn_wr=0.
- core_hold=1, load_done=0, load_error=0, checksum=0, counter=0.
REQ-031 Reset asserted mid-LOAD SHALL abort the load.
- No dn_wr is issued after reset is asserted.
- The loader stays in IDLE until the next rising edge of a selected ioctl_download.

Verification
REQ-032 Full image, index 0, 245760 sequential bytes of value 8'h01 -> 245760 dn_wr pulses, checksum=16'hC000, state DONE, core_hold=0.
REQ-033 Short image of 1000 bytes -> load_error=1, core_hold=1, load_done=0, dn_wr count=1000.
REQ-034 Full image plus one write at addr 245760 -> no dn_wr for that byte, ERROR, checksum unchanged by the extra byte.
REQ-035 Index 1 transfer during DONE -> no dn_wr, state remains DONE, checksum unchanged.
REQ-036 Reset pulse after 500 bytes, then a full reload -> IDLE with checksum 0 after the pulse; the reload ends in DONE with the correct checksum.
REQ-037 ioctl_wr on consecutive cycles, with the last strobe coincident with the falling ioctl_download -> dn_wr consecutive at latency 1, last byte counted, DONE.
